// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and grant ids.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick. req[0] is instruction fetch, req[1] is load/store.
// Purely combinational; the history register lives in the parent.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Lone requester wins outright; on contention the one not served last wins.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_IF;
    if (req == 2'b11) gnt_id = ~last_gnt;
    else if (req[1])  gnt_id = GNT_LS;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto the single-ported memory,
// sequences a fixed-latency access and returns a one-cycle done pulse.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  // The latched grant doubles as the round-robin history (last_gnt).
  logic              r_gnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic [1:0]        w_req;
  logic              w_gnt_valid;
  logic              w_gnt_id;
  logic              w_last_cycle;

  assign w_req        = {ls_req, if_req};
  assign w_last_cycle = (r_state == ST_ACCESS) && (r_cnt == '0);

  arb_rr2 u_arb (
    .req       (w_req),
    .last_gnt  (r_gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  // FSM, latency counter and grant history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gnt   <= GNT_IF;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_state <= ST_ACCESS;
            r_cnt   <= CNT_LOAD;
            r_gnt   <= w_gnt_id;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == '0) r_state <= ST_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Memory port registers, loaded from the winner at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (r_state == ST_IDLE && w_gnt_valid) begin
      if (w_gnt_id == GNT_LS) begin
        r_mem_we    <= ls_we;
        r_mem_addr  <= ls_addr;
        r_mem_wdata <= ls_wdata;
      end else begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end
    end
  end

  // Read data capture in the final access cycle; stores leave rdata untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else if (w_last_cycle && !r_mem_we) begin
      if (r_gnt == GNT_LS) r_ls_rdata <= mem_rdata;
      else                 r_if_rdata <= mem_rdata;
    end
  end

  // Status and strobes come from registered state only.
  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = r_mem_we & mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign if_done   = (r_state == ST_RESP) && (r_gnt == GNT_IF);
  assign ls_done   = (r_state == ST_RESP) && (r_gnt == GNT_LS);
  assign if_rdata  = r_if_rdata;
  assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT = 2.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [14:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [14:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic [15:0] ls_rdata;
  logic        ls_done;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(15), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifr;
    logic [14:0] ifa;
    logic        lsr;
    logic        lswe;
    logic [14:0] lsa;
    logic [15:0] lswd;
    logic [15:0] mrd;
    logic        en;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wd;
    logic        ifd;
    logic        lsd;
    logic        bsy;
    logic [15:0] ifrd;
    logic [15:0] lsrd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic ifr, input logic [14:0] ifa, input logic lsr, input logic lswe,
                     input logic [14:0] lsa, input logic [15:0] lswd, input logic [15:0] mrd,
                     input logic en, input logic we, input logic [14:0] addr, input logic [15:0] wd,
                     input logic ifd, input logic lsd, input logic bsy,
                     input logic [15:0] ifrd, input logic [15:0] lsrd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.lsr = lsr; v.lswe = lswe; v.lsa = lsa; v.lswd = lswd; v.mrd = mrd;
    v.en = en; v.we = we; v.addr = addr; v.wd = wd; v.ifd = ifd; v.lsd = lsd; v.bsy = bsy;
    v.ifrd = ifrd; v.lsrd = lsrd;
    tbl.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    next_cycle();
  endtask

  int done_id[8];
  int done_cyc[8];
  int n_done;
  int overlap;
  int wait_cyc;

  initial begin
    // Reset values, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_en", 0, mem_en, 0);
    chk("rst_mem_we", 0, mem_we, 0);
    chk("rst_mem_addr", 0, mem_addr, 0);
    chk("rst_mem_wdata", 0, mem_wdata, 0);
    chk("rst_if_rdata", 0, if_rdata, 0);
    chk("rst_ls_rdata", 0, ls_rdata, 0);
    chk("rst_if_done", 0, if_done, 0);
    chk("rst_ls_done", 0, ls_done, 0);
    chk("rst_busy", 0, busy, 0);
    do_reset();

    // ifr ifa lsr we lsa lswd mrd | en we addr wd ifd lsd busy ifrd lsrd
    // Lone fetch
    add(1, 15'h0010, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    add(1, 15'h0010, 0, 0, 15'h0000, 16'h0000, 16'hDEAD, 1, 0, 15'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    add(1, 15'h0010, 0, 0, 15'h0000, 16'h0000, 16'hA5A5, 1, 0, 15'h0010, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    add(1, 15'h0010, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0010, 16'h0000, 1, 0, 1, 16'hA5A5, 16'h0000);
    add(0, 15'h0010, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0010, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h0000);
    // Load
    add(0, 15'h0000, 1, 0, 15'h0300, 16'h0000, 16'h0000, 0, 0, 15'h0010, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h0000);
    add(0, 15'h0000, 1, 0, 15'h0300, 16'h0000, 16'h1111, 1, 0, 15'h0300, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h0000);
    add(0, 15'h0000, 1, 0, 15'h0300, 16'h0000, 16'h5A5A, 1, 0, 15'h0300, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h0000);
    add(0, 15'h0000, 1, 0, 15'h0300, 16'h0000, 16'h0000, 0, 0, 15'h0300, 16'h0000, 0, 1, 1, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0000, 0, 0, 15'h0300, 16'h0000, 16'h0000, 0, 0, 15'h0300, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h5A5A);
    // Store: ls_rdata must keep the loaded word
    add(0, 15'h0000, 1, 1, 15'h0200, 16'h1234, 16'h0000, 0, 0, 15'h0300, 16'h0000, 0, 0, 0, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0000, 1, 1, 15'h0200, 16'h1234, 16'h7777, 1, 1, 15'h0200, 16'h1234, 0, 0, 1, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0000, 1, 1, 15'h0200, 16'h1234, 16'h8888, 1, 1, 15'h0200, 16'h1234, 0, 0, 1, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0000, 1, 1, 15'h0200, 16'h1234, 16'h0000, 0, 0, 15'h0200, 16'h1234, 0, 1, 1, 16'hA5A5, 16'h5A5A);
    // Fetch whose request is withdrawn in the first access cycle
    add(1, 15'h0044, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0200, 16'h1234, 0, 0, 0, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0044, 0, 0, 15'h0000, 16'h0000, 16'h0000, 1, 0, 15'h0044, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0044, 0, 0, 15'h0000, 16'h0000, 16'h0BEE, 1, 0, 15'h0044, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h5A5A);
    add(0, 15'h0044, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0044, 16'h0000, 1, 0, 1, 16'h0BEE, 16'h5A5A);
    // Idle for 20 cycles
    for (int k = 0; k < 20; k++)
      add(0, 15'h0000, 0, 0, 15'h0000, 16'h0000, 16'h0000, 0, 0, 15'h0044, 16'h0000, 0, 0, 0, 16'h0BEE, 16'h5A5A);

    foreach (tbl[i]) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
      ls_req = tbl[i].lsr; ls_we = tbl[i].lswe; ls_addr = tbl[i].lsa; ls_wdata = tbl[i].lswd;
      mem_rdata = tbl[i].mrd;
      @(negedge clk);
      chk("mem_en", i, mem_en, tbl[i].en);
      chk("mem_we", i, mem_we, tbl[i].we);
      chk("mem_addr", i, mem_addr, tbl[i].addr);
      chk("mem_wdata", i, mem_wdata, tbl[i].wd);
      chk("if_done", i, if_done, tbl[i].ifd);
      chk("ls_done", i, ls_done, tbl[i].lsd);
      chk("busy", i, busy, tbl[i].bsy);
      chk("if_rdata", i, if_rdata, tbl[i].ifrd);
      chk("ls_rdata", i, ls_rdata, tbl[i].lsrd);
      next_cycle();
    end

    // Contention after reset: LS, IF, LS, IF with dones at cycles 3, 7, 11, 15.
    do_reset();
    if_req = 1'b1; if_addr = 15'h0011;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 15'h0222;
    n_done = 0; overlap = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if_done && ls_done) overlap++;
      if ((if_done || ls_done) && n_done < 8) begin
        done_id[n_done]  = ls_done ? 1 : 0;
        done_cyc[n_done] = c;
        n_done++;
      end
      next_cycle();
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("cont_overlap", 0, overlap, 0);
    chk("cont_ndone", 0, n_done, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n_done) begin
        chk("cont_order", k, done_id[k], (k % 2 == 0) ? 1 : 0);
        chk("cont_cycle", k, done_cyc[k], 3 + 4 * k);
      end
    end

    // Reset mid-access: complete one fetch, start another, reset in its 2nd access cycle.
    do_reset();
    if_req = 1'b1; if_addr = 15'h0055;
    next_cycle();               // cycle 1
    next_cycle();               // cycle 2
    mem_rdata = 16'hCAFE;
    next_cycle();               // cycle 3 (RESP)
    mem_rdata = 16'h0000;
    if_req = 1'b0;
    next_cycle();               // cycle 4
    @(negedge clk);
    chk("mr_first_rdata", 0, if_rdata, 16'hCAFE);
    next_cycle();               // cycle 5
    if_req = 1'b1; if_addr = 15'h0066;
    next_cycle();               // cycle 6, first access cycle
    next_cycle();               // cycle 7, second access cycle
    chk("mr_pre_en", 0, mem_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_mem_en", 0, mem_en, 0);
    chk("mr_busy", 0, busy, 0);
    chk("mr_if_rdata", 0, if_rdata, 0);
    chk("mr_ls_rdata", 0, ls_rdata, 0);
    chk("mr_if_done", 0, if_done, 0);
    if_req = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    next_cycle();
    overlap = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_done || ls_done || busy) overlap++;
      next_cycle();
    end
    chk("mr_no_done", 0, overlap, 0);
    // Fresh fetch after release
    if_req = 1'b1; if_addr = 15'h0077;
    wait_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      mem_rdata = (c == 2) ? 16'hBEEF : 16'h0000;
      @(negedge clk);
      if (if_done && wait_cyc < 0) begin
        wait_cyc = c;
        chk("mr_fresh_rdata", 0, if_rdata, 16'hBEEF);
        chk("mr_fresh_ls_done", 0, ls_done, 0);
        if_req = 1'b0;
      end
      next_cycle();
    end
    chk("mr_fresh_done_cycle", 0, wait_cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
